// File: rtl/noc_vc_requester_if.sv
// Handshake bundle between the requester flit buffer and its neighbours.
// Groups upstream push, arbiter request/grant/update, downstream flit and error.
// slave: the requester's view. master: the environment's view (upstream, arbiter, output port).
interface noc_vc_requester_if #(
    parameter int FLIT_W = 34
);
    logic              in_valid_i;
    logic [FLIT_W-1:0] in_flit_i;
    logic              in_ready_o;
    logic [1:0]        req_o;
    logic [1:0]        grant_i;
    logic              update_o;
    logic              out_valid_o;
    logic [FLIT_W-1:0] out_flit_o;
    logic [1:0]        out_sel_o;
    logic              out_ready_i;
    logic              err_o;

    modport slave (
        input  in_valid_i, in_flit_i, grant_i, out_ready_i,
        output in_ready_o, req_o, update_o, out_valid_o, out_flit_o, out_sel_o, err_o
    );

    modport master (
        output in_valid_i, in_flit_i, grant_i, out_ready_i,
        input  in_ready_o, req_o, update_o, out_valid_o, out_flit_o, out_sel_o, err_o
    );
endinterface

// File: rtl/noc_vc_requester.sv
// Input-port flit buffer that requests one of two outputs per packet and forwards flits while granted.
// Latency: push->head visible 1 cycle, ->req 2 cycles, ->first flit out 3 cycles with immediate grant.
// Backpressure: in_ready_o drops when the FIFO is full; output stalls on missing grant or out_ready_i.
// Ports: clk, arst (async active-low), bus (slave modport): in_* push side, req_o/grant_i/update_o
// toward the arbiter, out_* flit toward the output port, err_o pulse on dropped orphan body/tail.
module noc_vc_requester #(
    parameter int FLIT_W    = 34,
    parameter int DEPTH     = 4,
    parameter int ROUTE_BIT = 0
) (
    input  logic                  clk,
    input  logic                  arst,
    noc_vc_requester_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] TY_SINGLE = 2'b00;
    localparam logic [1:0] TY_HEAD   = 2'b01;
    localparam logic [1:0] TY_BODY   = 2'b10;
    localparam logic [1:0] TY_TAIL   = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state, state_nxt;
    logic              route_q, route_nxt;

    logic [FLIT_W-1:0] head_flit;
    logic [1:0]        head_type;
    logic              fifo_nempty, is_head, is_orphan, pkt_end;
    logic [1:0]        req;
    logic              granted, push, pop, xfer;
    logic              out_valid, update, drop;

    assign head_flit   = mem[rd_ptr];
    assign head_type   = head_flit[FLIT_W-1 -: 2];
    assign fifo_nempty = (count != '0);
    assign is_head     = (head_type == TY_HEAD) || (head_type == TY_SINGLE);
    assign is_orphan   = (head_type == TY_BODY) || (head_type == TY_TAIL);
    assign pkt_end     = (head_type == TY_TAIL) || (head_type == TY_SINGLE);

    // Request is a pure decode of registered state and the latched route, so it
    // stays constant for the whole packet and the arbiter's grant cannot move.
    assign req     = (state != IDLE) ? {route_q, ~route_q} : 2'b00;
    assign granted = |(bus.grant_i & req);

    assign push = bus.in_valid_i & bus.in_ready_o;
    assign xfer = out_valid & bus.out_ready_i;
    assign pop  = xfer | drop;

    // FIFO storage: unreset, contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_flit_i;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            route_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            route_q <= route_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        route_nxt = route_q;
        case (state)
            IDLE: begin
                if (fifo_nempty && is_head) begin
                    state_nxt = REQ;
                    route_nxt = head_flit[ROUTE_BIT];
                end
            end
            REQ: begin
                if (granted) state_nxt = SEND;
            end
            SEND: begin
                // A head seen mid-packet is just forwarded; only tail/single ends it.
                if (xfer && pkt_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_valid = 1'b0;
        update    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: drop = fifo_nempty && is_orphan;
            SEND: begin
                out_valid = fifo_nempty && granted;
                update    = out_valid && bus.out_ready_i && pkt_end;
            end
            default: ;
        endcase
    end

    assign bus.in_ready_o  = (count != FULL);
    assign bus.req_o       = req;
    assign bus.out_sel_o   = req;
    assign bus.out_valid_o = out_valid;
    assign bus.out_flit_o  = head_flit;
    assign bus.update_o    = update;
    assign bus.err_o       = drop;
endmodule

// File: tb/tb_noc_vc_requester.sv
module tb_noc_vc_requester;
    localparam int FW = 34;

    localparam logic [FW-1:0] Z   = '0;
    localparam logic [FW-1:0] H0  = {2'b01, 32'h0000_00A0};
    localparam logic [FW-1:0] H1  = {2'b01, 32'h0000_00A1};
    localparam logic [FW-1:0] B   = {2'b10, 32'h0000_00B1};
    localparam logic [FW-1:0] B2  = {2'b10, 32'h0000_00B2};
    localparam logic [FW-1:0] B3  = {2'b10, 32'h0000_00B3};
    localparam logic [FW-1:0] T   = {2'b11, 32'h0000_00C0};
    localparam logic [FW-1:0] S0  = {2'b00, 32'h0000_0050};
    localparam logic [FW-1:0] S1  = {2'b00, 32'h0000_0051};
    localparam logic [FW-1:0] S1B = {2'b00, 32'h0000_0053};

    // One stimulus cycle: inputs, then expected {in_ready, req, sel, out_valid, update, err}
    // and the expected out_flit when out_valid is expected.
    typedef struct packed {
        logic          vld;
        logic [FW-1:0] flit;
        logic [1:0]    gnt;
        logic          rdy;
        logic [7:0]    st;
        logic [FW-1:0] xf;
    } row_t;

    logic clk = 1'b0;
    logic arst;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] status;

    noc_vc_requester_if #(.FLIT_W(FW)) bus ();

    noc_vc_requester #(.FLIT_W(FW), .DEPTH(4), .ROUTE_BIT(0)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign status = {bus.in_ready_o, bus.req_o, bus.out_sel_o, bus.out_valid_o, bus.update_o, bus.err_o};

    task automatic test_reset();
        row_t t1 [3];
        row_t t2 [7];
        t1 = '{
            '{1'b1, H0, 2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_01_01_000, Z}
        };
        t2 = '{
            '{1'b1, H1, 2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, T,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_100, H1},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_110, T},
            '{1'b0, Z,  2'b00, 1'b0, 8'b1_00_00_000, Z},
            '{1'b0, Z,  2'b00, 1'b0, 8'b1_00_00_000, Z}
        };
        #1;
        checks++;
        if (status !== 8'b1_00_00_000) begin
            failures++;
            $display("FAIL reset_initial status got=%b exp=%b", status, 8'b1_00_00_000);
        end
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_i = t1[i].vld; bus.in_flit_i = t1[i].flit;
            bus.grant_i = t1[i].gnt; bus.out_ready_i = t1[i].rdy;
            #1;
            checks++;
            if (status !== t1[i].st) begin
                failures++;
                $display("FAIL reset_pre row %0d status got=%b exp=%b", i, status, t1[i].st);
            end
            @(negedge clk);
        end
        // Mid-packet asynchronous reset: outputs must clear without a clock edge.
        arst = 1'b0;
        #1;
        checks++;
        if (status !== 8'b1_00_00_000) begin
            failures++;
            $display("FAIL reset_async status got=%b exp=%b", status, 8'b1_00_00_000);
        end
        @(negedge clk);
        arst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid_i = t2[i].vld; bus.in_flit_i = t2[i].flit;
            bus.grant_i = t2[i].gnt; bus.out_ready_i = t2[i].rdy;
            #1;
            checks++;
            if (status !== t2[i].st) begin
                failures++;
                $display("FAIL reset_post row %0d status got=%b exp=%b", i, status, t2[i].st);
            end
            if (t2[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t2[i].xf) begin
                    failures++;
                    $display("FAIL reset_post row %0d flit got=%h exp=%h", i, bus.out_flit_o, t2[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_grant_transfer();
        row_t t [8];
        t = '{
            '{1'b1, H0, 2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, T,  2'b10, 1'b1, 8'b1_01_01_000, Z},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_000, Z},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_100, H0},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_100, B},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_110, T},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_00_00_000, Z}
        };
        for (int i = 0; i < 8; i++) begin
            bus.in_valid_i = t[i].vld; bus.in_flit_i = t[i].flit;
            bus.grant_i = t[i].gnt; bus.out_ready_i = t[i].rdy;
            #1;
            checks++;
            if (status !== t[i].st) begin
                failures++;
                $display("FAIL grant_transfer row %0d status got=%b exp=%b", i, status, t[i].st);
            end
            if (t[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t[i].xf) begin
                    failures++;
                    $display("FAIL grant_transfer row %0d flit got=%h exp=%h", i, bus.out_flit_o, t[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_fifo();
        row_t t [16];
        t = '{
            '{1'b1, H0,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B,   2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B2,  2'b00, 1'b1, 8'b1_01_01_000, Z},
            '{1'b1, B3,  2'b00, 1'b1, 8'b1_01_01_000, Z},
            '{1'b1, T,   2'b00, 1'b1, 8'b0_01_01_000, Z},
            '{1'b1, T,   2'b00, 1'b1, 8'b0_01_01_000, Z},
            '{1'b1, T,   2'b01, 1'b1, 8'b0_01_01_000, Z},
            '{1'b1, T,   2'b01, 1'b1, 8'b0_01_01_100, H0},
            '{1'b1, T,   2'b01, 1'b1, 8'b1_01_01_100, B},
            '{1'b1, S1,  2'b01, 1'b1, 8'b1_01_01_100, B2},
            '{1'b0, Z,   2'b01, 1'b1, 8'b1_01_01_100, B3},
            '{1'b0, Z,   2'b01, 1'b1, 8'b1_01_01_110, T},
            '{1'b0, Z,   2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,   2'b10, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,   2'b10, 1'b1, 8'b1_10_10_110, S1},
            '{1'b0, Z,   2'b00, 1'b1, 8'b1_00_00_000, Z}
        };
        for (int i = 0; i < 16; i++) begin
            bus.in_valid_i = t[i].vld; bus.in_flit_i = t[i].flit;
            bus.grant_i = t[i].gnt; bus.out_ready_i = t[i].rdy;
            #1;
            checks++;
            if (status !== t[i].st) begin
                failures++;
                $display("FAIL full_fifo row %0d status got=%b exp=%b", i, status, t[i].st);
            end
            if (t[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t[i].xf) begin
                    failures++;
                    $display("FAIL full_fifo row %0d flit got=%h exp=%h", i, bus.out_flit_o, t[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_grant_stall();
        row_t t [10];
        t = '{
            '{1'b1, H1, 2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, T,  2'b10, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_100, H1},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_100, B},
            '{1'b0, Z,  2'b10, 1'b1, 8'b1_10_10_110, T},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_00_00_000, Z}
        };
        for (int i = 0; i < 10; i++) begin
            bus.in_valid_i = t[i].vld; bus.in_flit_i = t[i].flit;
            bus.grant_i = t[i].gnt; bus.out_ready_i = t[i].rdy;
            #1;
            checks++;
            if (status !== t[i].st) begin
                failures++;
                $display("FAIL grant_stall row %0d status got=%b exp=%b", i, status, t[i].st);
            end
            if (t[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t[i].xf) begin
                    failures++;
                    $display("FAIL grant_stall row %0d flit got=%h exp=%h", i, bus.out_flit_o, t[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_orphan();
        row_t t [9];
        t = '{
            '{1'b1, T,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, B,  2'b00, 1'b1, 8'b1_00_00_001, Z},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_00_00_001, Z},
            '{1'b1, H0, 2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, T,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_000, Z},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_100, H0},
            '{1'b0, Z,  2'b01, 1'b1, 8'b1_01_01_110, T},
            '{1'b0, Z,  2'b00, 1'b1, 8'b1_00_00_000, Z}
        };
        for (int i = 0; i < 9; i++) begin
            bus.in_valid_i = t[i].vld; bus.in_flit_i = t[i].flit;
            bus.grant_i = t[i].gnt; bus.out_ready_i = t[i].rdy;
            #1;
            checks++;
            if (status !== t[i].st) begin
                failures++;
                $display("FAIL orphan row %0d status got=%b exp=%b", i, status, t[i].st);
            end
            if (t[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t[i].xf) begin
                    failures++;
                    $display("FAIL orphan row %0d flit got=%h exp=%h", i, bus.out_flit_o, t[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_single();
        row_t t [11];
        t = '{
            '{1'b1, S1,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, S0,  2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b1, S1B, 2'b10, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,   2'b10, 1'b1, 8'b1_10_10_110, S1},
            '{1'b0, Z,   2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,   2'b01, 1'b1, 8'b1_01_01_000, Z},
            '{1'b0, Z,   2'b01, 1'b1, 8'b1_01_01_110, S0},
            '{1'b0, Z,   2'b00, 1'b1, 8'b1_00_00_000, Z},
            '{1'b0, Z,   2'b10, 1'b1, 8'b1_10_10_000, Z},
            '{1'b0, Z,   2'b10, 1'b1, 8'b1_10_10_110, S1B},
            '{1'b0, Z,   2'b00, 1'b1, 8'b1_00_00_000, Z}
        };
        for (int i = 0; i < 11; i++) begin
            bus.in_valid_i = t[i].vld; bus.in_flit_i = t[i].flit;
            bus.grant_i = t[i].gnt; bus.out_ready_i = t[i].rdy;
            #1;
            checks++;
            if (status !== t[i].st) begin
                failures++;
                $display("FAIL single row %0d status got=%b exp=%b", i, status, t[i].st);
            end
            if (t[i].st[2]) begin
                checks++;
                if (bus.out_flit_o !== t[i].xf) begin
                    failures++;
                    $display("FAIL single row %0d flit got=%h exp=%h", i, bus.out_flit_o, t[i].xf);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        arst           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_flit_i   = '0;
        bus.grant_i     = 2'b00;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_grant_transfer();
        test_full_fifo();
        test_grant_stall();
        test_orphan();
        test_back_to_back_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_vc_requester.md
Name: noc_vc_requester

Overview:
- Input-port flit buffer on the requester side of the 2-output round-robin arbitration path.
- Buffers incoming flits and decodes the route of each head flit.
- Drives a one-hot request to the output arbiter, holds it for the whole packet, and forwards flits only while granted.
- Pulses update_o on the tail flit so the arbiter rotates priority.

Parameters:
- FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are the type field, the rest is payload.
- DEPTH, 4, FIFO entries; power of two, >=2.
- ROUTE_BIT, 0, payload bit of a head flit that selects the output: 0 -> output 0, 1 -> output 1.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  reset; asynchronous and active-low.
- in_valid_i  input  1  upstream flit valid.
- in_flit_i  input  FLIT_W  upstream flit.
- in_ready_o  output  1  FIFO can accept; a push happens when in_valid_i & in_ready_o.
- req_o  output  2  one-hot request to the arbiter req_i.
- grant_i  input  2  one-hot grant from the arbiter grant_o.
- update_o  output  1  to the arbiter update_i; pulses on the tail transfer.
- out_valid_o  output  1  flit valid toward the output port.
- out_flit_o  output  FLIT_W  FIFO head flit.
- out_sel_o  output  2  one-hot output select; equals req_o.
- out_ready_i  input  1  downstream accept; a transfer happens when out_valid_o & out_ready_i.
- err_o  output  1  one-cycle pulse when an orphan body or tail flit is dropped.

Behaviour:
- Flit type encoding: 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 single (head and tail together).
- Reset (arst=0, asynchronous):
  - state=IDLE, FIFO flushed (count=0, pointers=0), req_o=2'b00, route latch=0.
  - Resulting outputs: in_ready_o=1, out_valid_o=0, update_o=0, err_o=0.
  - A reset mid-packet discards all buffered flits; no update_o is issued.
- FIFO:
  - Circular buffer, count width $clog2(DEPTH+1).
  - in_ready_o = (count != DEPTH); pushes are registered.
  - A pushed flit is visible at out_flit_o the next cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
  - Pop happens only on an output transfer or an orphan drop.
- FSM with registered state and req_o:
  - IDLE:
    - If count!=0 and the head type is 01 or 00: latch route = head payload[ROUTE_BIT], set req_o one-hot from route next cycle, go to REQ.
    - If count!=0 and the head type is 10 or 11: pop it, pulse err_o that cycle, stay IDLE.
  - REQ: hold req_o. If (grant_i & req_o) != 0, go to SEND next cycle. Any other grant_i value is ignored.
  - SEND:
    - Hold req_o for the whole packet, so the arbiter mask cannot move and the grant stays stable.
    - out_valid_o = (count!=0) & ((grant_i & req_o)!=0). A missing grant stalls the packet without error.
    - On transfer of a tail or single flit: update_o=1 combinationally in that same cycle, next state IDLE, req_o=00 next cycle.
    - On transfer of a head flit that is not the first flit of the packet: treated as body (forwarded). No re-route happens.
- Latency, empty FIFO in IDLE:
  - Flit pushed in cycle 0, head visible in cycle 1, req_o asserted in cycle 2.
  - With an immediate grant, SEND and out_valid_o in cycle 3.
  - After a tail transfer in cycle N, IDLE in cycle N+1 and the next req_o in cycle N+2 (one idle cycle between packets).
- out_sel_o = req_o at all times. out_flit_o is don't-care when out_valid_o=0.
- update_o is never asserted outside a SEND-state tail transfer. err_o is only asserted in IDLE.

Test Plan:
- Reset check: arst=0 mid-stream -> immediately in_ready_o=1, req_o=00, out_valid_o=0, update_o=0. After release, a 2-flit packet {head payload[0]=1, tail} -> req_o=10 two cycles after the head push.
- Grant and transfer: push head(route 0), body, tail; grant_i=01 held, out_ready_i=1 -> out_valid_o for 3 consecutive cycles, out_sel_o=01, update_o=1 only on the tail cycle, req_o=00 the cycle after.
- Full FIFO: push 4 flits with grant_i=00 -> in_ready_o=0 after the 4th push, count stays 4. Then grant_i=01 with out_ready_i=1 and in_valid_i=1 -> in_ready_o=1 the next cycle; simultaneous push/pop keeps count stable.
- Grant stall: in SEND, drop grant_i to 00 for 3 cycles mid-packet -> out_valid_o=0, req_o held, no update_o. Restore grant -> remaining flits sent in order.
- Orphan drop: body flit arrives in IDLE -> err_o one pulse, flit discarded, req_o stays 00. A following head flit is then requested normally.
- Single-flit packets: push three type-00 flits with routes 1,0,1 -> req_o sequence 10,01,10, each packet with its own update_o pulse, one idle cycle between packets.
